conv_maxpool2x2: RTL

Streaming 2×2 max-pooling stage that sits directly downstream of the CONV layer-0 datapath. It consumes the 64×64 post-ReLU convolution output in raster order, one 20-bit pixel per accepted beat. It writes the 32×32 pooled result to layer-1 memory over the `cwr`/`caddr_wr`/`cdata_wr`/`csel` write port, using the same protocol the layer-0 write side already uses. It replaces the read-back-and-pool pass, so layer 1 completes as layer 0 streams.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_maxpool2x2_if.sv | 28 ++
 rtl/pool_line_buf.sv | 24 ++
 rtl/conv_maxpool2x2.sv | 89 ++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the CONV layer pipeline.
// Pooling stage state and pixel type live here.
package conv_pkg;

    localparam int DATA_W = 20;
    localparam int IMG_W  = 64;
    localparam int LOG_W  = $clog2(IMG_W);
    localparam int CNT_W  = 2 * LOG_W;
    localparam int ADDR_W = 12;

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    typedef logic [DATA_W-1:0] pix_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } pool_state_t;

    function automatic pix_t pmax(pix_t a, pix_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/conv_maxpool2x2_if.sv
// Pixel stream in, layer-1 memory write port out.
// master = pixel producer / memory sink, slave = pooling stage.
interface conv_maxpool2x2_if;
    import conv_pkg::*;

    logic        in_valid;
    pix_t        in_data;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        cwr;
    logic [11:0] caddr_wr;
    pix_t        cdata_wr;
    logic [2:0]  csel;

    modport master (
        output in_valid, in_data,
        input  in_ready, busy, done,
        input  cwr, caddr_wr, cdata_wr, csel
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, busy, done,
        output cwr, caddr_wr, cdata_wr, csel
    );

endinterface

// File: rtl/pool_line_buf.sv
// Half-width line buffer holding horizontal pair maxima of even rows.
// Sync write, async read, storage not reset.
module pool_line_buf
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [LOG_W-2:0] waddr,
    input  pix_t             wdata,
    input  logic [LOG_W-2:0] raddr,
    output pix_t             rdata
);

    pix_t mem [IMG_W/2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/conv_maxpool2x2.sv
// Streaming 2x2 max-pool over the 64x64 conv output,
// writing the 32x32 result straight into layer-1 memory.
module conv_maxpool2x2
    import conv_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    conv_maxpool2x2_if.slave   bus
);

    pool_state_t      state;
    logic [CNT_W-1:0] cnt;
    pix_t             h;

    logic [LOG_W-1:0] row;
    logic [LOG_W-1:0] col;
    logic             accept;
    logic             lb_we;
    pix_t             pair;
    pix_t             lb_rd;
    pix_t             quad;

    assign row    = cnt[CNT_W-1 -: LOG_W];
    assign col    = cnt[LOG_W-1:0];
    assign accept = bus.in_valid & bus.in_ready;
    assign pair   = pmax(h, bus.in_data);
    assign quad   = pmax(pair, lb_rd);
    assign lb_we  = accept & ~row[0] & col[0];

    pool_line_buf u_lb (
        .clk   (clk),
        .we    (lb_we),
        .waddr (col[LOG_W-1:1]),
        .wdata (pair),
        .raddr (col[LOG_W-1:1]),
        .rdata (lb_rd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            h            <= '0;
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.cwr      <= 1'b0;
            bus.caddr_wr <= '0;
            bus.cdata_wr <= '0;
            bus.csel     <= 3'b000;
        end else begin
            bus.cwr  <= 1'b0;
            bus.csel <= 3'b000;
            bus.done <= 1'b0;
            unique case (state)
                IDLE, RUN: begin
                    if (accept) begin
                        cnt      <= cnt + CNT_W'(1);
                        bus.busy <= 1'b1;
                        if (!col[0]) begin
                            h <= bus.in_data;
                        end
                        // bottom-right pixel of a quad completes it
                        if (row[0] & col[0]) begin
                            bus.cwr      <= 1'b1;
                            bus.csel     <= CSEL_L1;
                            bus.caddr_wr <= ADDR_W'({row[LOG_W-1:1], col[LOG_W-1:1]});
                            bus.cdata_wr <= quad;
                        end
                        if (&cnt) begin
                            state        <= DONE;
                            bus.done     <= 1'b1;
                            bus.in_ready <= 1'b0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    bus.busy     <= 1'b0;
                    bus.in_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
